// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and default widths for the imem/dmem main-memory port arbiter.
package mem_port_arbiter_pkg;

   localparam int unsigned MAIN_MEMORY_READ_SIZE = 32;
   localparam int unsigned ADDR_W_DEF            = 32;
   localparam int unsigned DATA_W_DEF            = MAIN_MEMORY_READ_SIZE;
   localparam int unsigned STARVE_LIMIT_DEF      = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      I_BUSY = 2'd1,
      D_BUSY = 2'd2,
      I_DROP = 2'd3
   } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Request/response and memory-side signals of the shared memory port.
// The slave modport is the arbiter's view; master is the pipeline/memory side.
interface mem_port_arbiter_if
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned DATA_W = DATA_W_DEF
);
   logic              imem_req;
   logic [ADDR_W-1:0] imem_addr;
   logic              imem_gnt;
   logic              imem_valid;
   logic [DATA_W-1:0] imem_rdata;
   logic              flush;
   logic              dmem_re;
   logic              dmem_wr;
   logic [ADDR_W-1:0] dmem_addr;
   logic [DATA_W-1:0] dmem_wdata;
   logic              dmem_gnt;
   logic              dmem_valid;
   logic [DATA_W-1:0] dmem_rdata;
   logic              mem_re;
   logic              mem_wr;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_ready;
   logic              busy;

   modport slave (
      input  imem_req, imem_addr, flush, dmem_re, dmem_wr, dmem_addr, dmem_wdata,
             mem_rdata, mem_ready,
      output imem_gnt, imem_valid, imem_rdata, dmem_gnt, dmem_valid, dmem_rdata,
             mem_re, mem_wr, mem_addr, mem_wdata, busy
   );

   modport master (
      output imem_req, imem_addr, flush, dmem_re, dmem_wr, dmem_addr, dmem_wdata,
             mem_rdata, mem_ready,
      input  imem_gnt, imem_valid, imem_rdata, dmem_gnt, dmem_valid, dmem_rdata,
             mem_re, mem_wr, mem_addr, mem_wdata, busy
   );
endinterface

// File: rtl/mem_port_arbiter_starve_counter.sv
// Saturating dmem-over-imem starvation counter with clear (module arb_starve_counter).
// Only compiled when MEM_ARB_STARVE_GUARD_EN is defined.
`ifdef MEM_ARB_STARVE_GUARD_EN
module arb_starve_counter #(
   parameter int unsigned LIMIT = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic inc,
   input  logic clr,
   output logic full_c
);
   localparam int unsigned CNT_W = $clog2(LIMIT + 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Clear wins over increment; count sticks at LIMIT.
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && (cnt_q != CNT_W'(LIMIT))) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign full_c = (cnt_q == CNT_W'(LIMIT));
endmodule
`endif

// File: rtl/mem_port_arbiter.sv
// Single-outstanding arbiter for the shared main-memory port (fetch vs load/store).
// Define MEM_ARB_STARVE_GUARD_EN to let a starved fetch win over dmem after STARVE_LIMIT grants.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned DATA_W = DATA_W_DEF
`ifdef MEM_ARB_STARVE_GUARD_EN
   ,
   parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
`endif
) (
   input logic              clk,
   input logic              rst,
   mem_port_arbiter_if.slave bus
);
   arb_state_e        state_q, state_d;
   logic              mem_re_q, mem_re_d;
   logic              mem_wr_q, mem_wr_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic              imem_valid_q, imem_valid_d;
   logic [DATA_W-1:0] imem_rdata_q, imem_rdata_d;
   logic              dmem_valid_q, dmem_valid_d;
   logic [DATA_W-1:0] dmem_rdata_q, dmem_rdata_d;

   logic idle_c;
   logic dmem_req_c;
   logic imem_req_c;
   logic grant_d_c;
   logic grant_i_c;

   // A requester still holds its request during its own valid cycle, so mask it there.
   assign idle_c     = (state_q == IDLE);
   assign dmem_req_c = (bus.dmem_re | bus.dmem_wr) & ~dmem_valid_q;
   assign imem_req_c = bus.imem_req & ~imem_valid_q & ~bus.flush;

`ifdef MEM_ARB_STARVE_GUARD_EN
   logic starve_full_c;

   assign grant_d_c = idle_c & dmem_req_c & ~(starve_full_c & imem_req_c);

   arb_starve_counter #(
      .LIMIT (STARVE_LIMIT)
   ) u_arb_starve_counter (
      .clk    (clk),
      .rst    (rst),
      .inc    (grant_d_c & bus.imem_req),
      .clr    (grant_i_c),
      .full_c (starve_full_c)
   );
`else
   assign grant_d_c = idle_c & dmem_req_c;
`endif

   assign grant_i_c = idle_c & imem_req_c & ~grant_d_c;

   // Next-state, capture and response logic.
   always_comb begin
      state_d      = state_q;
      mem_re_d     = mem_re_q;
      mem_wr_d     = mem_wr_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      imem_valid_d = 1'b0;
      imem_rdata_d = imem_rdata_q;
      dmem_valid_d = 1'b0;
      dmem_rdata_d = dmem_rdata_q;
      unique case (state_q)
         IDLE: begin
            if (grant_d_c) begin
               state_d     = D_BUSY;
               mem_re_d    = ~bus.dmem_wr;
               mem_wr_d    = bus.dmem_wr;
               mem_addr_d  = bus.dmem_addr;
               mem_wdata_d = bus.dmem_wr ? bus.dmem_wdata : '0;
            end else if (grant_i_c) begin
               state_d     = I_BUSY;
               mem_re_d    = 1'b1;
               mem_wr_d    = 1'b0;
               mem_addr_d  = bus.imem_addr;
               mem_wdata_d = '0;
            end
         end
         I_BUSY: begin
            if (bus.mem_ready) begin
               state_d  = IDLE;
               mem_re_d = 1'b0;
               if (!bus.flush) begin
                  imem_valid_d = 1'b1;
                  imem_rdata_d = bus.mem_rdata;
               end
            end else if (bus.flush) begin
               state_d = I_DROP;
            end
         end
         D_BUSY: begin
            if (bus.mem_ready) begin
               state_d      = IDLE;
               mem_re_d     = 1'b0;
               mem_wr_d     = 1'b0;
               dmem_valid_d = 1'b1;
               dmem_rdata_d = mem_wr_q ? '0 : bus.mem_rdata;
            end
         end
         I_DROP: begin
            if (bus.mem_ready) begin
               state_d  = IDLE;
               mem_re_d = 1'b0;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         mem_re_q     <= 1'b0;
         mem_wr_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         imem_valid_q <= 1'b0;
         imem_rdata_q <= '0;
         dmem_valid_q <= 1'b0;
         dmem_rdata_q <= '0;
      end else begin
         state_q      <= state_d;
         mem_re_q     <= mem_re_d;
         mem_wr_q     <= mem_wr_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         imem_valid_q <= imem_valid_d;
         imem_rdata_q <= imem_rdata_d;
         dmem_valid_q <= dmem_valid_d;
         dmem_rdata_q <= dmem_rdata_d;
      end
   end

   // Grants are same-cycle pulses; hold them low while reset is asserted.
   assign bus.imem_gnt   = grant_i_c & rst;
   assign bus.dmem_gnt   = grant_d_c & rst;
   assign bus.imem_valid = imem_valid_q;
   assign bus.imem_rdata = imem_rdata_q;
   assign bus.dmem_valid = dmem_valid_q;
   assign bus.dmem_rdata = dmem_rdata_q;
   assign bus.mem_re     = mem_re_q;
   assign bus.mem_wr     = mem_wr_q;
   assign bus.mem_addr   = mem_addr_q;
   assign bus.mem_wdata  = mem_wdata_q;
   assign bus.busy       = (state_q != IDLE);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized transaction-level bench for mem_port_arbiter plus directed reset and fetch cases.
module tb_mem_port_arbiter;
   import mem_port_arbiter_pkg::*;

   localparam int unsigned AW  = 32;
   localparam int unsigned DW  = 32;
   localparam int          LIM = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   // Backing store: words never written read back as an address-derived pattern.
   logic [31:0] mem_arr [logic [31:0]];

   function automatic logic [31:0] mem_rd(input logic [31:0] a);
      if (mem_arr.exists(a)) return mem_arr[a];
      return {a[15:0], ~a[15:0]};
   endfunction

   // Port occupancy and current transaction.
   bit          free = 1'b1, own_d, cur_st, killed;
   logic [31:0] cur_addr, cur_wd;
   int          wait_n, wait_cnt;
   // Requester state: act = request held, out = granted and awaiting valid.
   bit          i_act, i_out, i_cool;
   bit          d_act, d_out, d_cool, d_st, d_re;
   logic [31:0] i_addr, d_addr, d_wd;
   bit          exp_iv, exp_dv;
   logic [31:0] exp_ir, exp_dr;
   int          starve;
   bit          allow_new;

   task automatic run_cycle();
      bit rdy, fl, el_i, el_d, eg_i, eg_d, frc, ireq, nxt_iv, nxt_dv;
      @(posedge clk);
      #1;
      rdy = 1'b0;
      if (!free) begin
         rdy = (wait_cnt == wait_n);
         wait_cnt++;
      end
      bus.mem_ready = free ? 1'($urandom_range(0, 1)) : rdy;
      bus.mem_rdata = (!free && rdy) ? mem_rd(cur_addr) : $urandom;

      if (i_cool) i_cool = 1'b0;
      else if (!i_act && allow_new && ($urandom_range(0, 1) == 1)) begin
         i_act  = 1'b1;
         i_addr = 32'h100 + (32'($urandom_range(0, 15)) << 2);
      end
      if (d_cool) d_cool = 1'b0;
      else if (!d_act && allow_new && ($urandom_range(0, 2) == 0)) begin
         d_act  = 1'b1;
         d_st   = 1'($urandom_range(0, 1));
         d_re   = 1'($urandom_range(0, 1));
         d_addr = 32'h2000 + (32'($urandom_range(0, 7)) << 2);
         d_wd   = $urandom;
      end
      fl   = i_act && allow_new && ($urandom_range(0, 9) == 0);
      ireq = i_act;

      bus.imem_req   = i_act;
      bus.imem_addr  = i_act ? i_addr : $urandom;
      bus.flush      = fl;
      bus.dmem_re    = d_act && (!d_st || d_re);
      bus.dmem_wr    = d_act && d_st;
      bus.dmem_addr  = d_act ? d_addr : $urandom;
      bus.dmem_wdata = d_act ? d_wd : $urandom;

      el_i = i_act && !i_out && !fl;
      el_d = d_act && !d_out;
      frc  = 1'b0;
`ifdef MEM_ARB_STARVE_GUARD_EN
      frc = (starve == LIM);
`endif
      eg_i = free && el_i && (frc || !el_d);
      eg_d = free && el_d && !eg_i;

      @(negedge clk);
      check_eq("imem_gnt", 32'(bus.imem_gnt), 32'(eg_i));
      check_eq("dmem_gnt", 32'(bus.dmem_gnt), 32'(eg_d));
      check_eq("busy", 32'(bus.busy), 32'(!free));
      check_eq("mem_re", 32'(bus.mem_re), 32'(!free && !(own_d && cur_st)));
      check_eq("mem_wr", 32'(bus.mem_wr), 32'(!free && own_d && cur_st));
      if (!free) begin
         check_eq("mem_addr", bus.mem_addr, cur_addr);
         if (own_d && cur_st) check_eq("mem_wdata", bus.mem_wdata, cur_wd);
      end
      check_eq("imem_valid", 32'(bus.imem_valid), 32'(exp_iv));
      if (exp_iv) check_eq("imem_rdata", bus.imem_rdata, exp_ir);
      check_eq("dmem_valid", 32'(bus.dmem_valid), 32'(exp_dv));
      if (exp_dv) check_eq("dmem_rdata", bus.dmem_rdata, exp_dr);

      nxt_iv = 1'b0;
      nxt_dv = 1'b0;
      if (exp_iv) begin i_act = 1'b0; i_out = 1'b0; i_cool = 1'b1; end
      if (exp_dv) begin d_act = 1'b0; d_out = 1'b0; d_cool = 1'b1; end
      if (fl) begin
         i_act = 1'b0;
         i_out = 1'b0;
         if (!free && !own_d) killed = 1'b1;
      end
      if (!free && rdy) begin
         if (own_d) begin
            nxt_dv = 1'b1;
            exp_dr = cur_st ? 32'h0 : mem_rd(cur_addr);
            if (cur_st) mem_arr[cur_addr] = cur_wd;
         end else if (!killed) begin
            nxt_iv = 1'b1;
            exp_ir = mem_rd(cur_addr);
         end
         free = 1'b1;
      end
      if (eg_i || eg_d) begin
         free     = 1'b0;
         own_d    = eg_d;
         killed   = 1'b0;
         wait_n   = int'($urandom_range(0, 3));
         wait_cnt = 0;
         if (eg_d) begin
            d_out    = 1'b1;
            cur_st   = d_st;
            cur_addr = d_addr;
            cur_wd   = d_wd;
            if (ireq && starve < LIM) starve++;
         end else begin
            i_out    = 1'b1;
            cur_st   = 1'b0;
            cur_addr = i_addr;
            starve   = 0;
         end
      end
      exp_iv = nxt_iv;
      exp_dv = nxt_dv;
   endtask

   initial begin
      rst            = 1'b0;
      bus.imem_req   = 1'b1;
      bus.imem_addr  = 32'h100;
      bus.flush      = 1'b0;
      bus.dmem_re    = 1'b1;
      bus.dmem_wr    = 1'b1;
      bus.dmem_addr  = 32'h2000;
      bus.dmem_wdata = 32'h1234_5678;
      bus.mem_rdata  = 32'hFFFF_FFFF;
      bus.mem_ready  = 1'b1;
      repeat (3) @(negedge clk);
      // Requests held high during reset must not produce grants.
      check_eq("rst_imem_gnt", 32'(bus.imem_gnt), 32'h0);
      check_eq("rst_dmem_gnt", 32'(bus.dmem_gnt), 32'h0);
      check_eq("rst_busy", 32'(bus.busy), 32'h0);
      check_eq("rst_mem_re", 32'(bus.mem_re), 32'h0);
      check_eq("rst_mem_wr", 32'(bus.mem_wr), 32'h0);
      check_eq("rst_mem_addr", bus.mem_addr, 32'h0);
      check_eq("rst_imem_valid", 32'(bus.imem_valid), 32'h0);
      check_eq("rst_dmem_valid", 32'(bus.dmem_valid), 32'h0);
      bus.imem_req = 1'b0;
      bus.dmem_re  = 1'b0;
      bus.dmem_wr  = 1'b0;
      @(negedge clk);
      rst = 1'b1;

      allow_new = 1'b1;
      repeat (3000) run_cycle();
      allow_new = 1'b0;
      repeat (24) run_cycle();
      check_eq("drain_free", 32'(free), 32'h1);

      // Reset during a store: strobes drop without a clock edge, no valid follows.
      @(posedge clk);
      #1;
      bus.imem_req   = 1'b0;
      bus.flush      = 1'b0;
      bus.dmem_re    = 1'b0;
      bus.dmem_wr    = 1'b1;
      bus.dmem_addr  = 32'h2000;
      bus.dmem_wdata = 32'hDEAD_BEEF;
      bus.mem_ready  = 1'b0;
      @(negedge clk);
      check_eq("rm_dmem_gnt", 32'(bus.dmem_gnt), 32'h1);
      @(posedge clk);
      #1;
      check_eq("rm_mem_wr", 32'(bus.mem_wr), 32'h1);
      check_eq("rm_mem_addr", bus.mem_addr, 32'h2000);
      check_eq("rm_mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
      #2 rst = 1'b0;
      #1;
      check_eq("rm_async_mem_wr", 32'(bus.mem_wr), 32'h0);
      check_eq("rm_async_busy", 32'(bus.busy), 32'h0);
      check_eq("rm_async_dmem_gnt", 32'(bus.dmem_gnt), 32'h0);
      check_eq("rm_async_mem_addr", bus.mem_addr, 32'h0);
      check_eq("rm_async_mem_wdata", bus.mem_wdata, 32'h0);
      bus.dmem_wr = 1'b0;
      @(negedge clk);
      rst = 1'b1;

      // Zero-wait fetch after reset release.
      @(posedge clk);
      #1;
      bus.imem_req  = 1'b1;
      bus.imem_addr = 32'h100;
      bus.mem_ready = 1'b1;
      bus.mem_rdata = 32'h0000_0013;
      @(negedge clk);
      check_eq("f_imem_gnt", 32'(bus.imem_gnt), 32'h1);
      check_eq("f_dmem_gnt", 32'(bus.dmem_gnt), 32'h0);
      @(negedge clk);
      check_eq("f_mem_re", 32'(bus.mem_re), 32'h1);
      check_eq("f_mem_wr", 32'(bus.mem_wr), 32'h0);
      check_eq("f_mem_addr", bus.mem_addr, 32'h100);
      check_eq("f_early_valid", 32'(bus.imem_valid), 32'h0);
      check_eq("f_no_dmem_valid", 32'(bus.dmem_valid), 32'h0);
      @(negedge clk);
      check_eq("f_imem_valid", 32'(bus.imem_valid), 32'h1);
      check_eq("f_imem_rdata", bus.imem_rdata, 32'h0000_0013);
      check_eq("f_regrant_masked", 32'(bus.imem_gnt), 32'h0);
      check_eq("f_mem_re_drop", 32'(bus.mem_re), 32'h0);
      @(posedge clk);
      #1;
      bus.imem_req = 1'b0;
      @(negedge clk);
      check_eq("f_valid_pulse", 32'(bus.imem_valid), 32'h0);
      check_eq("f_busy_after", 32'(bus.busy), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
